// File: rtl/product_acc_pkg.sv
// Shared types for the product accumulator stage of the (A+B)*C pipeline.
//   PROD_W      : width of the signed product coming from the multiplier stage
//   acc_state_t : accumulator FSM state encoding
package product_acc_pkg;

  localparam int PROD_W = 31;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_resize.sv
// Combinational width conversion of the accumulated sum to the output width.
// Optional feature macro: ACC_SAT_EN (clip instead of wrap when narrowing).
// Ports:
//   din  in  ACC_W  signed accumulator value
//   dout out OUT_W  signed resized value
//   sat  out 1      dout was clipped (only when narrowing with ACC_SAT_EN)
module acc_resize #(
  parameter int ACC_W = 35,
  parameter int OUT_W = 35
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  generate
    if (OUT_W >= ACC_W) begin : g_extend
      // Size cast of a signed operand sign-extends.
      assign dout = OUT_W'(din);
      assign sat  = 1'b0;
    end else begin : g_narrow
`ifdef ACC_SAT_EN
      // The value fits only if every bit from the output sign bit upward agrees.
      localparam int HI_W = ACC_W - OUT_W + 1;
      logic [HI_W-1:0] hi;
      logic            in_range;

      assign hi       = din[ACC_W-1:OUT_W-1];
      assign in_range = (hi == '0) || (hi == '1);

      always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (!in_range) begin
          sat  = 1'b1;
          dout = din[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
`else
      logic unused_hi;

      assign dout      = din[OUT_W-1:0];
      assign sat       = 1'b0;
      assign unused_hi = ^din[ACC_W-1:OUT_W];
`endif
    end
  endgenerate

endmodule

// File: rtl/product_accumulator.sv
// Accumulates ACC_LEN signed products (fewer on flush) and presents the sum
// with its sample count on a valid/ready output; the producer is stalled via
// in_ready while a result is pending.
// Optional feature macro: ACC_SAT_EN (saturating narrowing, see acc_resize).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ce                    clock enable; 0 freezes everything
//   in_data/in_valid/in_ready   product input handshake
//   flush                 close the current partial sum early
//   out_data/out_count/out_sat  result, sample count, clip flag
//   out_valid/out_ready   result handshake
//
// state | meaning
// ACCUM | accepting samples into acc/cnt
// DUMP  | closed: first cycle loads the output register, then waits for take
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int IN_W    = PROD_W,
  parameter int ACC_LEN = 16,
  parameter int CNT_W   = $clog2(ACC_LEN + 1),
  parameter int ACC_W   = IN_W + $clog2(ACC_LEN),
  parameter int OUT_W   = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

  acc_state_t              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;
  logic                    close;
  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_sat;

  assign in_ready = (state == ACCUM);
  assign accept   = ce & in_valid & in_ready;
  assign in_ext   = ACC_W'(in_data);
  assign cnt_inc  = cnt + 1'b1;

  // A flush with nothing collected and no sample arriving is a no-op.
  assign close = ce & (state == ACCUM) &
                 ((accept & (cnt_inc == LEN_C)) | (flush & ((cnt != '0) | accept)));

  // Resize works on the registered sum, so the output is loaded one edge
  // after the transition into DUMP.
  acc_resize #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_resize (
    .din  (acc),
    .dout (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc + in_ext;
            cnt <= cnt_inc;
          end
          if (close) state <= DUMP;
        end
        DUMP: begin
          if (!out_valid) begin
            out_data  <= rs_data;
            out_count <= cnt;
            out_sat   <= rs_sat;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int LEN = 4;
`ifdef ACC_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic signed [30:0] in_data = '0;

  logic               in_ready_w, out_valid_w, out_sat_w;
  logic signed [32:0] out_data_w;
  logic [2:0]         out_count_w;
  logic               in_ready_n, out_valid_n, out_sat_n;
  logic signed [31:0] out_data_n;
  logic [2:0]         out_count_n;

  product_accumulator #(.ACC_LEN(LEN)) dut_w (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .flush(flush), .out_data(out_data_w),
    .out_count(out_count_w), .out_sat(out_sat_w), .out_valid(out_valid_w),
    .out_ready(out_ready)
  );

  product_accumulator #(.ACC_LEN(LEN), .OUT_W(32)) dut_n (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_n), .flush(flush), .out_data(out_data_n),
    .out_count(out_count_n), .out_sat(out_sat_n), .out_valid(out_valid_n),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: samples collected since the last result, and a phase
  // 0 = collecting, 1 = result closed but not yet shown, 2 = result shown.
  int     q[$];
  int     phase = 0;
  longint exp_sum = 0;
  int     exp_cnt = 0;

  typedef struct {
    int     n;
    int     s[4];
    int     fl;      // 0 none, 1 flush in a separate cycle, 2 flush with last sample
    longint exp_sum;
    int     exp_cnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint nexp(input longint s);
    longint w;
    if (SAT_ON) begin
      w = s;
      if (s > MAX32) w = MAX32;
      if (s < MIN32) w = MIN32;
    end else begin
      w = s & 64'h0000_0000_FFFF_FFFF;
      if (w > MAX32) w = w - 64'sd4294967296;
    end
    return w;
  endfunction

  function automatic longint nsat(input longint s);
    return (SAT_ON && (s > MAX32 || s < MIN32)) ? 1 : 0;
  endfunction

  task automatic check_model();
    chk("in_ready", longint'(in_ready_w), (phase == 0) ? 1 : 0);
    chk("out_valid", longint'(out_valid_w), (phase == 2) ? 1 : 0);
    chk("in_ready_n", longint'(in_ready_n), (phase == 0) ? 1 : 0);
    chk("out_valid_n", longint'(out_valid_n), (phase == 2) ? 1 : 0);
    if (phase == 2) begin
      chk("out_data", longint'(out_data_w), exp_sum);
      chk("out_count", longint'(out_count_w), longint'(exp_cnt));
      chk("out_sat", longint'(out_sat_w), 0);
      chk("out_data_n", longint'(out_data_n), nexp(exp_sum));
      chk("out_count_n", longint'(out_count_n), longint'(exp_cnt));
      chk("out_sat_n", longint'(out_sat_n), nsat(exp_sum));
    end
  endtask

  task automatic cyc(input bit c, input bit v, input int d, input bit f, input bit r);
    ce = c;
    in_valid = v;
    in_data = d[30:0];
    flush = f;
    out_ready = r;
    @(posedge clk);
    #1;
    if (c) begin
      case (phase)
        0: begin
          if (v) q.push_back(d);
          if (q.size() == LEN || (f && q.size() > 0)) begin
            exp_sum = 0;
            foreach (q[i]) exp_sum += longint'(q[i]);
            exp_cnt = q.size();
            q.delete();
            phase = 1;
          end
        end
        1: phase = 2;
        default: if (r) phase = 0;
      endcase
    end
    check_model();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " out_data"}, longint'(out_data_w), 0);
    chk({nm, " out_count"}, longint'(out_count_w), 0);
    chk({nm, " out_valid"}, longint'(out_valid_w), 0);
    chk({nm, " out_sat"}, longint'(out_sat_w), 0);
    chk({nm, " out_data_n"}, longint'(out_data_n), 0);
    chk({nm, " out_valid_n"}, longint'(out_valid_n), 0);
  endtask

  initial begin
    tbl[0] = '{4, '{1, 2, 3, 4}, 0, 10, 4};
    tbl[1] = '{4, '{-5, -5, -5, -5}, 0, -20, 4};
    tbl[2] = '{2, '{7, 8, 0, 0}, 1, 15, 2};
    tbl[3] = '{2, '{2, 5, 0, 0}, 2, 7, 2};
    tbl[4] = '{3, '{-1, 1000, -3, 0}, 1, 996, 3};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset in_ready", longint'(in_ready_w), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++)
        cyc(1, 1, tbl[t].s[i], (tbl[t].fl == 2) && (i == tbl[t].n - 1), 1);
      if (tbl[t].fl == 1) cyc(1, 0, 0, 1, 1);
      chk($sformatf("vec%0d load-cycle valid", t), longint'(out_valid_w), 0);
      cyc(1, 0, 0, 0, 0);
      chk($sformatf("vec%0d valid", t), longint'(out_valid_w), 1);
      chk($sformatf("vec%0d sum", t), longint'(out_data_w), tbl[t].exp_sum);
      chk($sformatf("vec%0d count", t), longint'(out_count_w), longint'(tbl[t].exp_cnt));
      cyc(1, 0, 0, 0, 1);
    end

    // Back-pressure, then a burst starting right after the take.
    repeat (4) cyc(1, 1, -5, 0, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 9, 1, 0);
    chk("stall sum", longint'(out_data_w), -20);
    chk("stall in_ready", longint'(in_ready_w), 0);
    cyc(1, 1, 100, 0, 1);
    chk("after take in_ready", longint'(in_ready_w), 1);
    repeat (4) cyc(1, 1, 100, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("no-bubble sum", longint'(out_data_w), 400);
    cyc(1, 0, 0, 0, 1);

    // Flush with nothing collected is ignored.
    cyc(1, 0, 0, 1, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);
    chk("empty flush valid", longint'(out_valid_w), 0);

    // Clock-enable freeze mid-burst.
    cyc(1, 1, 3, 0, 1);
    cyc(1, 1, 4, 0, 1);
    repeat (5) cyc(0, 1, 50, 1, 1);
    cyc(1, 1, 5, 0, 1);
    cyc(1, 1, 6, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("ce freeze sum", longint'(out_data_w), 18);
    chk("ce freeze count", longint'(out_count_w), 4);
    cyc(1, 0, 0, 0, 1);

    // Reset mid-burst discards the partial sum and clears held outputs.
    cyc(1, 1, 7, 0, 1);
    cyc(1, 1, 7, 0, 1);
    rst_n = 1'b0;
    ce = 1'b0;
    in_valid = 1'b0;
    #1;
    check_zero("mid reset");
    q.delete();
    phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("post reset sum", longint'(out_data_w), 4);
    chk("post reset count", longint'(out_count_w), 4);
    cyc(1, 0, 0, 0, 1);

    // Narrow output: 4 * (2^30-1) = 2^32-4.
    repeat (4) cyc(1, 1, 1073741823, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("wide big sum", longint'(out_data_w), 64'sd4294967292);
    chk("narrow big sum", longint'(out_data_n), SAT_ON ? MAX32 : -4);
    chk("narrow big sat", longint'(out_sat_n), SAT_ON ? 1 : 0);
    cyc(1, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int r;
      int r2;
      int d;
      r = $urandom;
      r2 = $urandom;
      if (r[3:0] == 4'd0) d = 1073741823;
      else if (r[3:0] == 4'd1) d = -1073741824;
      else d = int'($signed(r2[30:0]));
      cyc($urandom_range(99, 0) < 90, $urandom_range(99, 0) < 70, d,
          $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
